// File: rtl/player_anim_pkg.sv
// Shared definitions for the player animation controller and the sprite
// ROM / palette muxing that consumes its sprite_id.
package player_anim_pkg;

    localparam int unsigned RUN_CNT_W   = 4;
    localparam int unsigned SHOOT_CNT_W = 6;
    localparam int unsigned FLASH_CNT_W = 2;
    localparam int unsigned POSE_W      = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_JUMP  = 2'd2,
        ST_SHOOT = 2'd3
    } anim_state_e;

    localparam logic [POSE_W-1:0] POSE_STAND = 3'd0;
    localparam logic [POSE_W-1:0] POSE_RUN_A = 3'd1;
    localparam logic [POSE_W-1:0] POSE_RUN_B = 3'd2;
    localparam logic [POSE_W-1:0] POSE_JUMP  = 3'd3;
    localparam logic [POSE_W-1:0] POSE_SHOOT = 3'd4;

    // sprite_id layout: facing selects the mirrored ROM half / palette bank
    typedef struct packed {
        logic              facing;
        logic [POSE_W-1:0] pose;
    } sprite_t;

    // Ground movement resolution: exactly one direction means running
    function automatic anim_state_e move_state(input logic left, input logic right);
        return (left ^ right) ? ST_RUN : ST_IDLE;
    endfunction

    // Facing follows a single held direction, holds otherwise (1 = left)
    function automatic logic next_facing(input logic cur, input logic left, input logic right);
        logic f;
        f = cur;
        if (left && !right) begin
            f = 1'b1;
        end else if (right && !left) begin
            f = 1'b0;
        end
        return f;
    endfunction

endpackage

// File: rtl/anim_frame_counter.sv
// Tick-enabled, loadable counter that wraps to 0 after reaching wrap_val.
// wrap_c flags the enabled cycle in which the wrap happens.
module anim_frame_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] wrap_val,
    output logic             wrap_c
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Load has priority; otherwise advance and wrap on enable
    always_comb begin
        count_d = count_q;
        wrap_c  = 1'b0;
        if (load) begin
            count_d = load_val;
        end else if (en) begin
            if (count_q == wrap_val) begin
                count_d = '0;
                wrap_c  = 1'b1;
            end else begin
                count_d = count_q + WIDTH'(1);
            end
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/player_anim_ctrl.sv
// Player sprite animation controller: IDLE/RUN/JUMP/SHOOT sequencing on
// frame_tick, registered sprite_id/pal_sel outputs.
// Optional feature macro: PLAYER_PAL_FLASH_EN (pal_sel flashes during SHOOT).
module player_anim_ctrl
    import player_anim_pkg::*;
#(
    parameter int unsigned RUN_PERIOD   = 8,
    parameter int unsigned SHOOT_FRAMES = 12
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_tick,
    input  logic       move_left,
    input  logic       move_right,
    input  logic       jump_req,
    input  logic       shoot_req,
    input  logic       on_ground,
    output logic [3:0] sprite_id,
    output logic       pal_sel,
    output logic       busy
);

    localparam logic [RUN_CNT_W-1:0]   RUN_WRAP   = RUN_CNT_W'(RUN_PERIOD - 1);
    localparam logic [SHOOT_CNT_W-1:0] SHOOT_WRAP = SHOOT_CNT_W'(SHOOT_FRAMES - 1);

    anim_state_e state_q;
    anim_state_e state_d;
    logic        jump_seen_q;
    logic        jump_seen_d;
    sprite_t     sprite_q;
    sprite_t     sprite_d;

    logic run_en;
    logic run_load;
    logic run_wrap_c;
    logic shoot_en;
    logic shoot_load;
    logic shoot_wrap_c;

    // Counter controls: advance while staying in the state, clear on entry
    assign run_en     = frame_tick && (state_q == ST_RUN) && (state_d == ST_RUN);
    assign run_load   = frame_tick && (state_q != ST_RUN) && (state_d == ST_RUN);
    assign shoot_en   = frame_tick && (state_q == ST_SHOOT);
    assign shoot_load = frame_tick && (state_q != ST_SHOOT) && (state_d == ST_SHOOT);

    anim_frame_counter #(.WIDTH(RUN_CNT_W)) u_run_cnt (
        .clk      (Clk),
        .rst_n    (Reset_n),
        .en       (run_en),
        .load     (run_load),
        .load_val ('0),
        .wrap_val (RUN_WRAP),
        .wrap_c   (run_wrap_c)
    );

    anim_frame_counter #(.WIDTH(SHOOT_CNT_W)) u_shoot_cnt (
        .clk      (Clk),
        .rst_n    (Reset_n),
        .en       (shoot_en),
        .load     (shoot_load),
        .load_val ('0),
        .wrap_val (SHOOT_WRAP),
        .wrap_c   (shoot_wrap_c)
    );

    // State register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= ST_IDLE;
            jump_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            jump_seen_q <= jump_seen_d;
        end
    end

    // Next state: shoot > grounded jump > movement; SHOOT is uninterruptible
    always_comb begin
        state_d     = state_q;
        jump_seen_d = jump_seen_q;
        if (frame_tick) begin
            // Set once a full tick has been spent airborne
            jump_seen_d = (state_q == ST_JUMP);
            case (state_q)
                ST_IDLE, ST_RUN: begin
                    if (shoot_req) begin
                        state_d = ST_SHOOT;
                    end else if (jump_req && on_ground) begin
                        state_d = ST_JUMP;
                    end else begin
                        state_d = move_state(move_left, move_right);
                    end
                end
                ST_JUMP: begin
                    if (shoot_req) begin
                        state_d = ST_SHOOT;
                    end else if (on_ground && jump_seen_q) begin
                        state_d = move_state(move_left, move_right);
                    end
                end
                ST_SHOOT: begin
                    if (shoot_wrap_c) begin
                        state_d = move_state(move_left, move_right);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Output next values: facing, pose, run-cycle toggle
    always_comb begin
        sprite_d = sprite_q;
        if (frame_tick) begin
            if (state_q != ST_SHOOT) begin
                sprite_d.facing = next_facing(sprite_q.facing, move_left, move_right);
            end
            case (state_d)
                ST_IDLE:  sprite_d.pose = POSE_STAND;
                ST_RUN: begin
                    if (state_q != ST_RUN) begin
                        sprite_d.pose = POSE_RUN_A;
                    end else if (run_wrap_c) begin
                        sprite_d.pose = (sprite_q.pose == POSE_RUN_A) ? POSE_RUN_B : POSE_RUN_A;
                    end
                end
                ST_JUMP:  sprite_d.pose = POSE_JUMP;
                ST_SHOOT: sprite_d.pose = POSE_SHOOT;
                default:  sprite_d.pose = POSE_STAND;
            endcase
        end
    end

    // Registered sprite outputs
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sprite_q <= '0;
        end else begin
            sprite_q <= sprite_d;
        end
    end

    assign sprite_id = sprite_q;
    assign busy      = (state_q == ST_JUMP) || (state_q == ST_SHOOT);

`ifdef PLAYER_PAL_FLASH_EN
    logic                   pal_sel_q;
    logic                   pal_sel_d;
    logic [FLASH_CNT_W-1:0] flash_cnt_q;
    logic [FLASH_CNT_W-1:0] flash_cnt_d;

    // Highlight flash: starts lit on SHOOT entry, flips every 4 ticks
    always_comb begin
        pal_sel_d   = pal_sel_q;
        flash_cnt_d = flash_cnt_q;
        if (frame_tick) begin
            if (state_d != ST_SHOOT) begin
                pal_sel_d   = 1'b0;
                flash_cnt_d = '0;
            end else if (state_q != ST_SHOOT) begin
                pal_sel_d   = 1'b1;
                flash_cnt_d = '0;
            end else begin
                if (flash_cnt_q == '1) begin
                    pal_sel_d = ~pal_sel_q;
                end
                flash_cnt_d = flash_cnt_q + FLASH_CNT_W'(1);
            end
        end
    end

    // Flash registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pal_sel_q   <= 1'b0;
            flash_cnt_q <= '0;
        end else begin
            pal_sel_q   <= pal_sel_d;
            flash_cnt_q <= flash_cnt_d;
        end
    end

    assign pal_sel = pal_sel_q;
`else
    assign pal_sel = 1'b0;
`endif

endmodule

// File: tb/tb_player_anim_ctrl.sv
// Bench for player_anim_ctrl: directed ticks with literal expectations plus
// a behavioural model compared against the outputs on every cycle.
module tb_player_anim_ctrl;

    localparam int RUN_P  = 8;
    localparam int SHOOT_F = 12;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       move_left = 1'b0;
    logic       move_right = 1'b0;
    logic       jump_req = 1'b0;
    logic       shoot_req = 1'b0;
    logic       on_ground = 1'b0;
    logic [3:0] sprite_id;
    logic       pal_sel;
    logic       busy;

    int total = 0;
    int bad = 0;

    player_anim_ctrl #(.RUN_PERIOD(RUN_P), .SHOOT_FRAMES(SHOOT_F)) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .frame_tick (frame_tick),
        .move_left  (move_left),
        .move_right (move_right),
        .jump_req   (jump_req),
        .shoot_req  (shoot_req),
        .on_ground  (on_ground),
        .sprite_id  (sprite_id),
        .pal_sel    (pal_sel),
        .busy       (busy)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 standing, 1 running, 2 airborne, 3 shooting
    int m_mode = 0;
    bit m_face = 0;
    int m_run_ticks = 0;   // ticks since RUN was entered
    int m_air_ticks = 0;   // ticks already spent in JUMP
    int m_shot_ticks = 0;  // ticks already spent in SHOOT

    function automatic int ground_mode(input bit l, input bit r);
        return (l != r) ? 1 : 0;
    endfunction

    always @(posedge Clk or negedge Reset_n) begin
        int prev;
        int nxt;
        if (!Reset_n) begin
            m_mode = 0; m_face = 0; m_run_ticks = 0; m_air_ticks = 0; m_shot_ticks = 0;
        end else if (frame_tick) begin
            prev = m_mode;
            nxt  = prev;
            if (prev <= 1) begin
                if (shoot_req) nxt = 3;
                else if (jump_req && on_ground) nxt = 2;
                else nxt = ground_mode(move_left, move_right);
            end else if (prev == 2) begin
                if (shoot_req) nxt = 3;
                else if (on_ground && m_air_ticks >= 1) nxt = ground_mode(move_left, move_right);
            end else begin
                if (m_shot_ticks + 1 == SHOOT_F) nxt = ground_mode(move_left, move_right);
            end
            if (prev != 3) begin
                if (move_left && !move_right) m_face = 1;
                else if (move_right && !move_left) m_face = 0;
            end
            m_run_ticks  = (nxt == 1 && prev == 1) ? m_run_ticks + 1 : 0;
            m_air_ticks  = (nxt == 2 && prev == 2) ? m_air_ticks + 1 : 0;
            m_shot_ticks = (nxt == 3 && prev == 3) ? m_shot_ticks + 1 : 0;
            m_mode = nxt;
        end
    end

    function automatic int exp_sprite();
        int pose;
        case (m_mode)
            0: pose = 0;
            1: pose = (((m_run_ticks / RUN_P) % 2) == 1) ? 2 : 1;
            2: pose = 3;
            default: pose = 4;
        endcase
        return (int'(m_face) << 3) | pose;
    endfunction

    function automatic int exp_pal();
`ifdef PLAYER_PAL_FLASH_EN
        return (m_mode == 3 && ((m_shot_ticks / 4) % 2) == 0) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge Clk) begin
        if ($time > 6) begin
            chk("model_sprite", int'(sprite_id), exp_sprite());
            chk("model_busy", int'(busy), (m_mode >= 2) ? 1 : 0);
            chk("model_pal", int'(pal_sel), exp_pal());
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input bit ml, input bit mr, input bit jr, input bit sr, input bit og);
        @(negedge Clk);
        move_left = ml; move_right = mr; jump_req = jr; shoot_req = sr; on_ground = og;
        frame_tick = 1'b1;
        @(negedge Clk);
        frame_tick = 1'b0;
        // inputs wander between ticks and must be ignored
        move_left = 1'($urandom); move_right = 1'($urandom);
        jump_req = 1'($urandom); shoot_req = 1'($urandom); on_ground = 1'($urandom);
        @(negedge Clk);
    endtask

    function automatic int flash_exp(input int k);
`ifdef PLAYER_PAL_FLASH_EN
        return ((k / 4) % 2 == 0) ? 1 : 0;
`else
        return 0 * k;
`endif
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        repeat (2) @(negedge Clk);
        chk("rst_sprite", int'(sprite_id), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_pal", int'(pal_sel), 0);
        Reset_n = 1'b1;
        tick(0, 0, 0, 0, 0);
        chk("idle_after_rst", int'(sprite_id), 0);

        // run cycle, facing left
        tick(1, 0, 0, 0, 1);
        chk("run_first", int'(sprite_id), 4'h9);
        repeat (7) tick(1, 0, 0, 0, 1);
        chk("run_hold7", int'(sprite_id), 4'h9);
        tick(1, 0, 0, 0, 1);
        chk("run_toggle_b", int'(sprite_id), 4'hA);
        repeat (8) tick(1, 0, 0, 0, 1);
        chk("run_toggle_a", int'(sprite_id), 4'h9);

        // both directions -> idle, facing held
        tick(1, 1, 0, 0, 1);
        chk("both_idle", int'(sprite_id), 4'h8);
        chk("both_busy", int'(busy), 0);

        // jump, airborne 5 ticks, land -> idle
        tick(0, 0, 1, 0, 1);
        chk("jump_sprite", int'(sprite_id), 4'hB);
        chk("jump_busy", int'(busy), 1);
        repeat (5) tick(0, 0, 0, 0, 0);
        chk("air_sprite", int'(sprite_id), 4'hB);
        tick(0, 0, 0, 0, 1);
        chk("land_sprite", int'(sprite_id), 4'h8);
        chk("land_busy", int'(busy), 0);

        // single-tick shoot pulse, move_right toggling must not alter facing
        tick(0, 0, 0, 1, 1);
        chk("shoot_sprite0", int'(sprite_id), 4'hC);
        chk("shoot_pal0", int'(pal_sel), flash_exp(0));
        for (int i = 1; i < SHOOT_F; i++) begin
            tick(0, 1'(i % 2), 0, 0, 1);
            chk("shoot_sprite", int'(sprite_id), 4'hC);
            chk("shoot_pal", int'(pal_sel), flash_exp(i));
        end
        tick(0, 0, 0, 0, 1);
        chk("shoot_exit", int'(sprite_id), 4'h8);
        chk("shoot_exit_busy", int'(busy), 0);
        chk("shoot_exit_pal", int'(pal_sel), 0);

        // priority: shoot beats jump and move; held shoot re-enters one tick later
        tick(0, 1, 1, 1, 1);
        chk("prio_pose", int'(sprite_id[2:0]), 4);
        chk("prio_busy", int'(busy), 1);
        repeat (SHOOT_F - 1) tick(0, 0, 0, 1, 1);
        chk("held_pose", int'(sprite_id[2:0]), 4);
        tick(0, 0, 0, 1, 1);
        chk("held_exit_pose", int'(sprite_id[2:0]), 0);
        tick(0, 0, 0, 1, 1);
        chk("reenter_pose", int'(sprite_id[2:0]), 4);

        // asynchronous reset mid-SHOOT
        repeat (3) tick(0, 0, 0, 0, 1);
        @(posedge Clk);
        #3;
        Reset_n = 1'b0;
        #1;
        chk("async_rst_sprite", int'(sprite_id), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_pal", int'(pal_sel), 0);
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        tick(0, 0, 0, 0, 0);
        chk("post_rst_idle", int'(sprite_id), 0);

        // model-checked mixed traffic
        for (int n = 0; n < 300; n++) begin
            tick(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 9) == 0),
                 1'($urandom_range(0, 1)));
        end

        @(negedge Clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/player_anim_ctrl.md
PLAYER_ANIM_CTRL -- requirements
Module: player_anim_ctrl

Interface
REQ-001 SHALL have parameter RUN_PERIOD, default 8: frame_ticks per run-cycle frame toggle (legal 1..15).
REQ-002 SHALL have parameter SHOOT_FRAMES, default 12: frame_ticks spent in SHOOT (legal 1..63).
REQ-003 SHALL have port Clk  input  1  sole clock; one clock, all logic on rising edge.
REQ-004 SHALL have port Reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port frame_tick  input  1  one-cycle pulse per vertical sync.
REQ-006 SHALL have ports move_left, move_right  input  1 each  level movement requests.
REQ-007 SHALL have ports jump_req, shoot_req  input  1 each  level action requests.
REQ-008 SHALL have port on_ground  input  1  player feet on floor.
REQ-009 SHALL have port sprite_id  output  4  {facing, pose[2:0]}, selects sprite ROM and palette bank.
REQ-010 SHALL have port pal_sel  output  1  palette variant select (0 normal, 1 highlight).
REQ-011 SHALL have port busy  output  1  high in JUMP or SHOOT.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, JUMP, SHOOT; state, counters and outputs update only in cycles where frame_tick=1.
REQ-013 SHALL register all outputs; changes appear the cycle after the frame_tick cycle (latency 1).
REQ-014 SHALL evaluate on each tick, priority order: shoot_req (from IDLE/RUN/JUMP) > jump_req with on_ground=1 (from IDLE/RUN) > movement.
REQ-015 SHALL, in IDLE/RUN, go to RUN when exactly one of move_left/move_right is high, else IDLE.
REQ-016 SHALL leave JUMP only on a tick with on_ground=1 and at least one prior tick spent in JUMP, exiting to RUN/IDLE per REQ-015.
REQ-017 SHALL hold SHOOT for exactly SHOOT_FRAMES ticks (6-bit counter), ignore all requests meanwhile, then exit per REQ-015; shoot_req still high at exit re-enters SHOOT on the next tick, not the same one.
REQ-018 SHALL set facing=1 (left) when only move_left is high, 0 when only move_right is high, hold when both or neither; facing frozen in SHOOT.
REQ-019 SHALL encode pose: 0 STAND (IDLE), 1 RUN_A, 2 RUN_B, 3 JUMP, 4 SHOOT; codes 5-7 never output.
REQ-020 SHALL, in RUN, toggle RUN_A/RUN_B every RUN_PERIOD ticks via a 4-bit counter that wraps to 0; entering RUN starts at RUN_A with counter 0.
REQ-021 SHALL assert busy combinationally from registered state (JUMP or SHOOT).
REQ-022 SHALL ignore input changes between ticks; only values sampled in the tick cycle count.

Reset
REQ-023 SHALL, on Reset_n=0 at any time, immediately force state IDLE, facing 0, sprite_id 4'h0, pal_sel 0, busy 0, all counters 0, aborting any SHOOT/JUMP.
REQ-024 SHALL resume normal operation at the first frame_tick after Reset_n deasserts.

Configuration
REQ-025 SHALL, with macro PLAYER_PAL_FLASH_EN defined, toggle pal_sel every 4 ticks while in SHOOT (starting 1 on SHOOT entry) and force pal_sel 0 outside SHOOT.
REQ-026 SHALL, without PLAYER_PAL_FLASH_EN, tie pal_sel to 0 and omit the flash counter.

Structure
REQ-027 SHALL place the state enum (IDLE/RUN/JUMP/SHOOT) and pose code constants in shared package player_anim_pkg, used also by sprite ROM/palette muxing.
REQ-028 SHALL use one sub-module, anim_frame_counter (tick-enabled, loadable, wrapping counter), instantiated for run and shoot timing.

Verification
REQ-029 SHALL cover reset: Reset_n=0 mid-SHOOT -> same-cycle sprite_id=0, busy=0; after release and idle tick sprite_id stays 0.
REQ-030 SHALL cover run: move_left held, RUN_PERIOD=8 -> sprite_id 4'h9 after first tick, 4'hA after 8 more ticks, 4'h9 after 8 more.
REQ-031 SHALL cover jump: jump_req with on_ground=1 -> sprite_id pose 3, busy=1; on_ground=0 for 5 ticks then 1 -> exit to IDLE on that tick.
REQ-032 SHALL cover shoot: shoot_req pulsed on one tick, SHOOT_FRAMES=12 -> pose 4 for exactly 12 ticks; move_right toggled meanwhile leaves facing unchanged.
REQ-033 SHALL cover priority: shoot_req, jump_req, move_right all high on one tick from IDLE -> SHOOT; both move inputs high -> IDLE, facing held.
REQ-034 SHALL cover PLAYER_PAL_FLASH_EN: defined -> pal_sel 1,1,1,1,0,0,0,0,1... during SHOOT, 0 after; undefined -> pal_sel constantly 0.
